alu_ctrl_seq: RTL and testbench

Registered, parametrised ALU controller for the multi-cycle CPU datapath.
- Decodes ALUOp/funct into an ALU control code, as the single-cycle decoder does.
- Adds a one-cycle output register, an extended opcode set (nor, shifts), and a multiply/divide sequencer.
- The sequencer stalls the pipeline for a programmable latency and pulses the HI/LO write enable.
- Sits between the main control unit / ID-EX register and the ALU / MDU.

---
 rtl/alu_ctrl_pkg.sv | 30 +++
 rtl/alu_ctrl_seq_if.sv | 25 ++
 rtl/alu_ctrl_dec.sv | 59 +++++
 rtl/alu_ctrl_seq.sv | 72 +++++++
 tb/tb_alu_ctrl_seq.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: ALUOp/funct/control-code constants and sequencer state type; build option ALU_CTRL_DIV_EN
package alu_ctrl_pkg;
  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_RTYPE = 3'b010;
  localparam logic [2:0] OP_SLT   = 3'b011;
  localparam logic [2:0] OP_OR    = 3'b100;
  localparam logic [2:0] OP_AND   = 3'b101;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_MULT = 6'b011000;
  localparam logic [5:0] FN_DIV  = 6'b011010;
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_MULT = 4'b1110;
  localparam logic [3:0] ALU_DIV  = 4'b1111;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
endpackage

// File: rtl/alu_ctrl_seq_if.sv
// alu_ctrl_seq_if: control-unit <-> ALU controller bus; master drives valid_i/ALUOp_i/funct_i, slave drives the rest
interface alu_ctrl_seq_if #(
  parameter int FUNCT_W = 6,
  parameter int ALUOP_W = 3,
  parameter int CTRL_W  = 4
);
  logic               valid_i;
  logic [ALUOP_W-1:0] ALUOp_i;
  logic [FUNCT_W-1:0] funct_i;
  logic [CTRL_W-1:0]  ALUCtrl_o;
  logic               valid_o;
  logic               stall_o;
  logic               mdu_start_o;
  logic               mdu_div_o;
  logic               hilo_we_o;
  logic               illegal_o;
  modport master (
    output valid_i, ALUOp_i, funct_i,
    input  ALUCtrl_o, valid_o, stall_o, mdu_start_o, mdu_div_o, hilo_we_o, illegal_o
  );
  modport slave (
    input  valid_i, ALUOp_i, funct_i,
    output ALUCtrl_o, valid_o, stall_o, mdu_start_o, mdu_div_o, hilo_we_o, illegal_o
  );
endinterface

// File: rtl/alu_ctrl_dec.sv
// alu_ctrl_dec: combinational (ALUOp, funct) -> {code, is_mdu, is_div, illegal}; div decode only with ALU_CTRL_DIV_EN
module alu_ctrl_dec
  import alu_ctrl_pkg::*;
#(
  parameter int FUNCT_W = 6,
  parameter int ALUOP_W = 3,
  parameter int CTRL_W  = 4
) (
  input  logic [ALUOP_W-1:0] alu_op_i,
  input  logic [FUNCT_W-1:0] funct_i,
  output logic [CTRL_W-1:0]  code_o,
  output logic               is_mdu_o,
  output logic               is_div_o,
  output logic               illegal_o
);
  logic [2:0] op;
  logic [5:0] fn;
  logic [3:0] c;
  assign op = alu_op_i[2:0];
  assign fn = funct_i[5:0];
  assign code_o = CTRL_W'(c);
  always_comb begin
    c = ALU_AND;
    is_mdu_o = 1'b0;
    is_div_o = 1'b0;
    illegal_o = 1'b0;
    case (op)
      OP_ADD: c = ALU_ADD;
      OP_SUB: c = ALU_SUB;
      OP_SLT: c = ALU_SLT;
      OP_OR:  c = ALU_OR;
      OP_AND: c = ALU_AND;
      OP_RTYPE:
        case (fn)
          FN_AND:  c = ALU_AND;
          FN_OR:   c = ALU_OR;
          FN_ADD:  c = ALU_ADD;
          FN_SUB:  c = ALU_SUB;
          FN_SLT:  c = ALU_SLT;
          FN_NOR:  c = ALU_NOR;
          FN_SLL:  c = ALU_SLL;
          FN_SRL:  c = ALU_SRL;
          FN_MULT: begin
            c = ALU_MULT;
            is_mdu_o = 1'b1;
          end
`ifdef ALU_CTRL_DIV_EN
          FN_DIV: begin
            c = ALU_DIV;
            is_mdu_o = 1'b1;
            is_div_o = 1'b1;
          end
`endif
          default: illegal_o = 1'b1;
        endcase
      default: illegal_o = 1'b1;
    endcase
  end
endmodule

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered ALU control decode with mult/div stall sequencer; build option ALU_CTRL_DIV_EN
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int FUNCT_W = 6,
  parameter int ALUOP_W = 3,
  parameter int CTRL_W  = 4,
  parameter int MUL_LAT = 8,
  parameter int DIV_LAT = 16,
  parameter int CNT_W   = 5
) (
  input logic           clk_i,
  input logic           rst_i,
  alu_ctrl_seq_if.slave bus
);
  logic [CTRL_W-1:0] code;
  logic              is_mdu, is_div, ill, accept, go_mdu;
  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic              valid_q, start_q, div_q, hilo_q, illegal_q;
  alu_ctrl_dec #(.FUNCT_W(FUNCT_W), .ALUOP_W(ALUOP_W), .CTRL_W(CTRL_W)) u_dec (
    .alu_op_i (bus.ALUOp_i),
    .funct_i  (bus.funct_i),
    .code_o   (code),
    .is_mdu_o (is_mdu),
    .is_div_o (is_div),
    .illegal_o(ill)
  );
  assign accept = bus.valid_i && state_q != S_BUSY;
  assign go_mdu = accept && !ill && is_mdu;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ctrl_q    <= '0;
      valid_q   <= 1'b0;
      start_q   <= 1'b0;
      div_q     <= 1'b0;
      hilo_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      valid_q   <= accept && !ill;
      illegal_q <= accept && ill;
      start_q   <= go_mdu;
      div_q     <= go_mdu && is_div;
      hilo_q    <= state_q == S_BUSY && cnt_q == '0;
      if (accept) ctrl_q <= ill ? '0 : code;
      if (state_q == S_BUSY) begin
        if (cnt_q == '0) state_q <= S_DONE;
        else cnt_q <= cnt_q - 1'b1;
      end else if (go_mdu) begin
        state_q <= S_BUSY;
        cnt_q   <= is_div ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
      end else begin
        // DONE lasts one cycle even if an illegal op arrives, so hilo_we_o never repeats
        state_q <= S_IDLE;
      end
    end
  end
  assign bus.ALUCtrl_o   = ctrl_q;
  assign bus.valid_o     = valid_q;
  assign bus.stall_o     = state_q == S_BUSY;
  assign bus.mdu_start_o = start_q;
`ifdef ALU_CTRL_DIV_EN
  assign bus.mdu_div_o   = div_q;
`else
  assign bus.mdu_div_o   = 1'b0;
`endif
  assign bus.hilo_we_o   = hilo_q;
  assign bus.illegal_o   = illegal_q;
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: directed vector table plus mult/div/reset sequences for alu_ctrl_seq
module tb_alu_ctrl_seq;
  logic clk, rst_n;
  int checks, errors;
  alu_ctrl_seq_if #(.FUNCT_W(6), .ALUOP_W(3), .CTRL_W(4)) bus ();
  alu_ctrl_seq #(.MUL_LAT(8), .DIV_LAT(16), .CNT_W(5)) dut (.clk_i(clk), .rst_i(rst_n), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {
    logic       v;
    logic [2:0] op;
    logic [5:0] fn;
    logic [3:0] ctrl;
    logic       vo;
    logic       ill;
  } vec_t;
  vec_t tbl[19];
  function automatic vec_t mk(logic v, logic [2:0] op, logic [5:0] fn, logic [3:0] ctrl, logic vo, logic ill);
    vec_t r;
    r.v = v; r.op = op; r.fn = fn; r.ctrl = ctrl; r.vo = vo; r.ill = ill;
    return r;
  endfunction
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [2:0] op, input logic [5:0] fn);
    bus.valid_i = v;
    bus.ALUOp_i = op;
    bus.funct_i = fn;
  endtask
  initial begin
    int hilo_seen;
    checks = 0;
    errors = 0;
    tbl[0]  = mk(1, 3'b010, 6'b100010, 4'b0110, 1, 0);
    tbl[1]  = mk(1, 3'b000, 6'b111111, 4'b0010, 1, 0);
    tbl[2]  = mk(1, 3'b001, 6'b000000, 4'b0110, 1, 0);
    tbl[3]  = mk(1, 3'b011, 6'b000000, 4'b0111, 1, 0);
    tbl[4]  = mk(1, 3'b100, 6'b000000, 4'b0001, 1, 0);
    tbl[5]  = mk(1, 3'b101, 6'b000000, 4'b0000, 1, 0);
    tbl[6]  = mk(1, 3'b010, 6'b100101, 4'b0001, 1, 0);
    tbl[7]  = mk(1, 3'b010, 6'b100100, 4'b0000, 1, 0);
    tbl[8]  = mk(1, 3'b010, 6'b100000, 4'b0010, 1, 0);
    tbl[9]  = mk(1, 3'b010, 6'b101010, 4'b0111, 1, 0);
    tbl[10] = mk(1, 3'b010, 6'b100111, 4'b1100, 1, 0);
    tbl[11] = mk(1, 3'b010, 6'b000000, 4'b1000, 1, 0);
    tbl[12] = mk(1, 3'b010, 6'b000010, 4'b1001, 1, 0);
    tbl[13] = mk(1, 3'b110, 6'b100000, 4'b0000, 0, 1);
    tbl[14] = mk(1, 3'b010, 6'b111111, 4'b0000, 0, 1);
    tbl[15] = mk(1, 3'b111, 6'b100000, 4'b0000, 0, 1);
    tbl[16] = mk(0, 3'b000, 6'b000000, 4'b0000, 0, 0);
    tbl[17] = mk(1, 3'b000, 6'b000000, 4'b0010, 1, 0);
    tbl[18] = mk(0, 3'b001, 6'b000000, 4'b0010, 0, 0);
    rst_n = 1'b0;
    drive(0, 3'b000, 6'b000000);
    #12;
    chk("rst_ctrl", 8'(bus.ALUCtrl_o), 8'h0);
    chk("rst_valid", 8'(bus.valid_o), 8'h0);
    chk("rst_stall", 8'(bus.stall_o), 8'h0);
    chk("rst_start", 8'(bus.mdu_start_o), 8'h0);
    chk("rst_hilo", 8'(bus.hilo_we_o), 8'h0);
    chk("rst_illegal", 8'(bus.illegal_o), 8'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].v, tbl[i].op, tbl[i].fn);
      tick();
      chk($sformatf("vec%0d_ctrl", i), 8'(bus.ALUCtrl_o), 8'(tbl[i].ctrl));
      chk($sformatf("vec%0d_valid", i), 8'(bus.valid_o), 8'(tbl[i].vo));
      chk($sformatf("vec%0d_illegal", i), 8'(bus.illegal_o), 8'(tbl[i].ill));
      chk($sformatf("vec%0d_stall", i), 8'(bus.stall_o), 8'h0);
    end
    drive(1, 3'b010, 6'b011000);
    tick();
    chk("mul_start", 8'(bus.mdu_start_o), 8'h1);
    chk("mul_div", 8'(bus.mdu_div_o), 8'h0);
    chk("mul_valid", 8'(bus.valid_o), 8'h1);
    chk("mul_ctrl", 8'(bus.ALUCtrl_o), 8'hE);
    chk("mul_stall1", 8'(bus.stall_o), 8'h1);
    drive(1, 3'b010, 6'b100010);
    for (int i = 2; i <= 8; i++) begin
      tick();
      chk($sformatf("mul_stall%0d", i), 8'(bus.stall_o), 8'h1);
      chk($sformatf("mul_busy_start%0d", i), 8'(bus.mdu_start_o), 8'h0);
      chk($sformatf("mul_busy_hilo%0d", i), 8'(bus.hilo_we_o), 8'h0);
      chk($sformatf("mul_busy_valid%0d", i), 8'(bus.valid_o), 8'h0);
      chk($sformatf("mul_busy_ctrl%0d", i), 8'(bus.ALUCtrl_o), 8'hE);
    end
    tick();
    chk("mul_done_hilo", 8'(bus.hilo_we_o), 8'h1);
    chk("mul_done_stall", 8'(bus.stall_o), 8'h0);
    tick();
    drive(0, 3'b000, 6'b000000);
    chk("sub_after_done_valid", 8'(bus.valid_o), 8'h1);
    chk("sub_after_done_ctrl", 8'(bus.ALUCtrl_o), 8'h6);
    chk("sub_after_done_hilo", 8'(bus.hilo_we_o), 8'h0);
    chk("sub_after_done_stall", 8'(bus.stall_o), 8'h0);
    drive(1, 3'b010, 6'b011010);
    tick();
    drive(0, 3'b000, 6'b000000);
`ifdef ALU_CTRL_DIV_EN
    chk("div_start", 8'(bus.mdu_start_o), 8'h1);
    chk("div_div", 8'(bus.mdu_div_o), 8'h1);
    chk("div_ctrl", 8'(bus.ALUCtrl_o), 8'hF);
    for (int i = 1; i <= 16; i++) begin
      chk($sformatf("div_stall%0d", i), 8'(bus.stall_o), 8'h1);
      tick();
    end
    chk("div_done_hilo", 8'(bus.hilo_we_o), 8'h1);
    chk("div_done_stall", 8'(bus.stall_o), 8'h0);
`else
    chk("div_illegal", 8'(bus.illegal_o), 8'h1);
    chk("div_valid", 8'(bus.valid_o), 8'h0);
    chk("div_stall", 8'(bus.stall_o), 8'h0);
    chk("div_start", 8'(bus.mdu_start_o), 8'h0);
    chk("div_ctrl", 8'(bus.ALUCtrl_o), 8'h0);
`endif
    tick();
    drive(1, 3'b010, 6'b011000);
    tick();
    drive(0, 3'b000, 6'b000000);
    tick();
    tick();
    chk("rstmid_stall_before", 8'(bus.stall_o), 8'h1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_stall", 8'(bus.stall_o), 8'h0);
    chk("rstmid_start", 8'(bus.mdu_start_o), 8'h0);
    chk("rstmid_ctrl", 8'(bus.ALUCtrl_o), 8'h0);
    #2;
    rst_n = 1'b1;
    hilo_seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.hilo_we_o !== 1'b0 || bus.stall_o !== 1'b0) hilo_seen++;
    end
    chk("rstmid_no_hilo_or_stall", 8'(hilo_seen), 8'h0);
    drive(1, 3'b000, 6'b000000);
    tick();
    drive(0, 3'b000, 6'b000000);
    chk("rstmid_add_ctrl", 8'(bus.ALUCtrl_o), 8'h2);
    chk("rstmid_add_valid", 8'(bus.valid_o), 8'h1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
